i2c_slave: RTL and testbench

Single-wire, clock-synchronous I2C-style read slave. It decodes an address byte and an 8-bit register pointer on bidirectional `sda`, then returns read-only register data MSB first. The block has no SCL: one bit slot equals one `clk` cycle, shared with the master. It sits on the system I2C segment as a read-only status/ID register target.

---
 rtl/i2c_slave_pkg.sv | 27 ++
 rtl/sda_iobuf.sv | 13 +
 rtl/i2c_slave.sv | 164 ++++++++++++++++
 tb/tb_i2c_slave.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the single-wire, clock-synchronous I2C read slave.
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_REG      = 3'd3,
        ST_REG_ACK  = 3'd4,
        ST_TX       = 3'd5,
        ST_MACK     = 3'd6,
        ST_DROP     = 3'd7
    } state_t;

    localparam logic [6:0] DEF_SLAVE_ADDR = 7'h2A;
    localparam logic [7:0] DEF_RD_MASK    = 8'h5A;

    // Slot counts: one byte is 8 slots; an ignored frame still owns ACK + 8 + ACK slots.
    localparam logic [3:0] BITS_PER_BYTE  = 4'd8;
    localparam logic [3:0] DROP_SLOTS     = 4'd10;

    // Read-only register file: the value at a pointer is the pointer scrambled by a mask.
    function automatic logic [7:0] rd_data(input logic [7:0] ptr, input logic [7:0] mask);
        return ptr ^ mask;
    endfunction

endpackage

// File: rtl/sda_iobuf.sv
// Tristate driver for the shared data line plus its input return path.
// The segment carries an external pull-up, so a released line reads high.
module sda_iobuf (
    input  logic oe,
    input  logic out,
    inout  wire  sda,
    output logic din
);

    assign sda = oe ? out : 1'bz;
    assign din = sda;

endmodule

// File: rtl/i2c_slave.sv
// Single-wire I2C-style read slave: address + pointer decode, then read data MSB first.
// One bit slot is one clk cycle; line drive (oe/out) is registered so it only
// changes just after a rising edge.
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter logic [7:0] RD_MASK    = DEF_RD_MASK
) (
    input  logic clk,
    input  logic rst,
    inout  wire  sda
);

    state_t      state_r, state_n;
    logic [3:0]  cnt_r, cnt_n;
    logic [7:0]  shreg_r, shreg_n;
    logic [7:0]  ptr_r, ptr_n;
    logic        rw_r, rw_n;
    logic        oe_r, oe_n;
    logic        out_r, out_n;
    logic        din_s;
    logic        bit_s;
    logic [7:0]  rx_byte_s;
    logic [7:0]  tx_cur_s;
    logic [7:0]  tx_inc_s;

    sda_iobuf u_iobuf (
        .oe  (oe_r),
        .out (out_r),
        .sda (sda),
        .din (din_s)
    );

    // Only a sampled low is a 0; a released (pulled-up) line is a 1.
    assign bit_s     = (din_s == 1'b0) ? 1'b0 : 1'b1;
    assign rx_byte_s = {shreg_r[6:0], bit_s};
    assign tx_cur_s  = rd_data(ptr_r, RD_MASK);
    assign tx_inc_s  = rd_data(ptr_r + 8'd1, RD_MASK);

    // State, datapath and line-drive registers; reset releases the line at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            shreg_r <= 8'h00;
            ptr_r   <= 8'h00;
            rw_r    <= 1'b0;
            oe_r    <= 1'b0;
            out_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            shreg_r <= shreg_n;
            ptr_r   <= ptr_n;
            rw_r    <= rw_n;
            oe_r    <= oe_n;
            out_r   <= out_n;
        end
    end

    // Next-state and next line drive; the line is released unless a slot claims it.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        shreg_n = shreg_r;
        ptr_n   = ptr_r;
        rw_n    = rw_r;
        oe_n    = 1'b0;
        out_n   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bit_s == 1'b0) begin
                    state_n = ST_ADDR;
                    cnt_n   = 4'd0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ADDR: begin
                shreg_n = rx_byte_s;
                if (cnt_r == BITS_PER_BYTE - 4'd1) begin
                    rw_n = bit_s;
                    if (rx_byte_s[7:1] == SLAVE_ADDR) begin
                        state_n = ST_ADDR_ACK;
                        cnt_n   = 4'd0;
                        oe_n    = 1'b1;
                        out_n   = 1'b0;
                    end else begin
                        // Not ours: sit out the rest of the frame without touching the line.
                        state_n = ST_DROP;
                        cnt_n   = DROP_SLOTS;
                    end
                end else begin
                    cnt_n = cnt_r + 4'd1;
                end
            end
            ST_ADDR_ACK: begin
                cnt_n = 4'd0;
                if (rw_r) begin
                    // Bit 7 goes out now; the rest is shifted from the top of shreg.
                    state_n = ST_TX;
                    shreg_n = {tx_cur_s[6:0], 1'b0};
                    oe_n    = 1'b1;
                    out_n   = tx_cur_s[7];
                end else begin
                    state_n = ST_REG;
                end
            end
            ST_REG: begin
                shreg_n = rx_byte_s;
                if (cnt_r == BITS_PER_BYTE - 4'd1) begin
                    ptr_n   = rx_byte_s;
                    state_n = ST_REG_ACK;
                    cnt_n   = 4'd0;
                    oe_n    = 1'b1;
                    out_n   = 1'b0;
                end else begin
                    cnt_n = cnt_r + 4'd1;
                end
            end
            ST_REG_ACK: begin
                // The sample here is our own ACK, so a new START is looked for next slot.
                state_n = ST_IDLE;
            end
            ST_TX: begin
                if (cnt_r == BITS_PER_BYTE - 4'd1) begin
                    state_n = ST_MACK;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n   = cnt_r + 4'd1;
                    shreg_n = {shreg_r[6:0], 1'b0};
                    oe_n    = 1'b1;
                    out_n   = shreg_r[7];
                end
            end
            ST_MACK: begin
                if (bit_s == 1'b0) begin
                    ptr_n   = ptr_r + 8'd1;
                    state_n = ST_TX;
                    cnt_n   = 4'd0;
                    shreg_n = {tx_inc_s[6:0], 1'b0};
                    oe_n    = 1'b1;
                    out_n   = tx_inc_s[7];
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (cnt_r <= 4'd1) begin
                    state_n = ST_IDLE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt_r - 4'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed self-checking bench for i2c_slave: the bench acts as an open-drain master.
module tb_i2c_slave;
    import i2c_slave_pkg::*;

    logic clk;
    logic rst;
    logic m_low;
    wire  sda;
    int   checks;
    int   failures;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave dut (
        .clk (clk),
        .rst (rst),
        .sda (sda)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bit slot: master sets its level at the falling edge, then the line settles.
    task automatic slot(input logic mbit);
        @(negedge clk);
        m_low = ~mbit;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) slot(b[i]);
    endtask

    task automatic recv_byte(output logic [7:0] d, output logic all_oe);
        all_oe = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            slot(1'b1);
            d[i] = sda;
            if (dut.oe_r !== 1'b1) all_oe = 1'b0;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst   = 1'b1;
        m_low = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut.oe_r !== 1'b0 || sda !== 1'b1) begin
            failures++;
            $display("FAIL reset_line: oe=%0b sda=%0b expected oe=0 sda=1", dut.oe_r, sda);
        end
        checks++;
        if (dut.state_r !== ST_IDLE || dut.ptr_r !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: state=%0d ptr=%h expected state=0 ptr=00", dut.state_r, dut.ptr_r);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            slot(1'b1);
            if (dut.oe_r !== 1'b0 || sda !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_after_reset: driven_slots=%0d expected 0", bad);
        end
    endtask

    task automatic test_pointer_write();
        slot(1'b0);
        send_byte(8'h54);
        slot(1'b1);
        checks++;
        if (dut.oe_r !== 1'b1 || sda !== 1'b0) begin
            failures++;
            $display("FAIL write_addr_ack: oe=%0b sda=%0b expected oe=1 sda=0", dut.oe_r, sda);
        end
        send_byte(8'hBE);
        slot(1'b1);
        checks++;
        if (dut.oe_r !== 1'b1 || sda !== 1'b0) begin
            failures++;
            $display("FAIL write_reg_ack: oe=%0b sda=%0b expected oe=1 sda=0", dut.oe_r, sda);
        end
        slot(1'b1);
        checks++;
        if (dut.ptr_r !== 8'hBE || dut.oe_r !== 1'b0) begin
            failures++;
            $display("FAIL write_pointer: ptr=%h oe=%0b expected ptr=be oe=0", dut.ptr_r, dut.oe_r);
        end
    endtask

    task automatic test_read();
        logic [7:0] d;
        logic       all_oe;
        slot(1'b0);
        send_byte(8'h55);
        slot(1'b1);
        checks++;
        if (dut.oe_r !== 1'b1 || sda !== 1'b0) begin
            failures++;
            $display("FAIL read_addr_ack: oe=%0b sda=%0b expected oe=1 sda=0", dut.oe_r, sda);
        end
        recv_byte(d, all_oe);
        checks++;
        if (d !== 8'hE4 || all_oe !== 1'b1) begin
            failures++;
            $display("FAIL read_data: data=%h drive=%0b expected data=e4 drive=1", d, all_oe);
        end
        slot(1'b1);
        checks++;
        if (dut.oe_r !== 1'b0) begin
            failures++;
            $display("FAIL read_mack_release: oe=%0b expected 0", dut.oe_r);
        end
        slot(1'b1);
        checks++;
        if (dut.oe_r !== 1'b0 || dut.state_r !== ST_IDLE || dut.ptr_r !== 8'hBE) begin
            failures++;
            $display("FAIL read_nack_idle: oe=%0b state=%0d ptr=%h expected oe=0 state=0 ptr=be",
                     dut.oe_r, dut.state_r, dut.ptr_r);
        end
    endtask

    // Write 0xFF, then a repeated START straight after REG_ACK and a two-byte read.
    task automatic test_back_to_back();
        logic [7:0] d;
        logic       all_oe;
        slot(1'b0);
        send_byte(8'h54);
        slot(1'b1);
        send_byte(8'hFF);
        slot(1'b1);
        checks++;
        if (dut.oe_r !== 1'b1 || sda !== 1'b0 || dut.ptr_r !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_write_ack: oe=%0b sda=%0b ptr=%h expected oe=1 sda=0 ptr=ff",
                     dut.oe_r, sda, dut.ptr_r);
        end
        slot(1'b0);
        send_byte(8'h55);
        slot(1'b1);
        checks++;
        if (dut.oe_r !== 1'b1 || sda !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart_ack: oe=%0b sda=%0b expected oe=1 sda=0", dut.oe_r, sda);
        end
        recv_byte(d, all_oe);
        checks++;
        if (d !== 8'hA5 || all_oe !== 1'b1) begin
            failures++;
            $display("FAIL b2b_byte0: data=%h drive=%0b expected data=a5 drive=1", d, all_oe);
        end
        slot(1'b0);
        recv_byte(d, all_oe);
        checks++;
        if (d !== 8'h5A || all_oe !== 1'b1 || dut.ptr_r !== 8'h00) begin
            failures++;
            $display("FAIL b2b_wrap_byte1: data=%h drive=%0b ptr=%h expected data=5a drive=1 ptr=00",
                     d, all_oe, dut.ptr_r);
        end
        slot(1'b1);
        slot(1'b1);
        checks++;
        if (dut.state_r !== ST_IDLE || dut.oe_r !== 1'b0) begin
            failures++;
            $display("FAIL b2b_nack_idle: state=%0d oe=%0b expected state=0 oe=0", dut.state_r, dut.oe_r);
        end
    endtask

    task automatic test_addr_mismatch();
        logic [7:0] d;
        logic       all_oe;
        int         bad;
        slot(1'b0);
        send_byte(8'h61);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            slot(1'b1);
            if (dut.oe_r !== 1'b0 || sda !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mismatch_silent: driven_slots=%0d expected 0", bad);
        end
        slot(1'b0);
        send_byte(8'h55);
        slot(1'b1);
        checks++;
        if (dut.oe_r !== 1'b1 || sda !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_next_ack: oe=%0b sda=%0b expected oe=1 sda=0", dut.oe_r, sda);
        end
        recv_byte(d, all_oe);
        checks++;
        if (d !== 8'h5A) begin
            failures++;
            $display("FAIL mismatch_next_data: data=%h expected 5a", d);
        end
        slot(1'b1);
        slot(1'b1);
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        logic       all_oe;
        logic [3:0] hi;
        slot(1'b0);
        send_byte(8'h54);
        slot(1'b1);
        send_byte(8'h33);
        slot(1'b1);
        slot(1'b1);
        slot(1'b0);
        send_byte(8'h55);
        slot(1'b1);
        for (int i = 3; i >= 0; i--) begin
            slot(1'b1);
            hi[i] = sda;
        end
        slot(1'b1);
        checks++;
        if (hi !== 4'h6 || dut.oe_r !== 1'b1) begin
            failures++;
            $display("FAIL midread_prefix: bits=%h oe=%0b expected bits=6 oe=1", hi, dut.oe_r);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dut.oe_r !== 1'b0 || sda !== 1'b1) begin
            failures++;
            $display("FAIL midread_async_release: oe=%0b sda=%0b expected oe=0 sda=1", dut.oe_r, sda);
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (dut.ptr_r !== 8'h00 || dut.state_r !== ST_IDLE) begin
            failures++;
            $display("FAIL midread_reset_state: ptr=%h state=%0d expected ptr=00 state=0", dut.ptr_r, dut.state_r);
        end
        slot(1'b1);
        slot(1'b0);
        send_byte(8'h55);
        slot(1'b1);
        recv_byte(d, all_oe);
        checks++;
        if (d !== 8'h5A || all_oe !== 1'b1) begin
            failures++;
            $display("FAIL midread_reread: data=%h drive=%0b expected data=5a drive=1", d, all_oe);
        end
        slot(1'b1);
        slot(1'b1);
    endtask

    task automatic test_stuck_low();
        logic [7:0] d;
        logic       all_oe;
        int         bad;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            slot(1'b0);
            if (dut.oe_r !== 1'b0) bad++;
        end
        for (int i = 0; i < 20; i++) begin
            slot(1'b1);
            if (dut.oe_r !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || dut.state_r !== ST_IDLE) begin
            failures++;
            $display("FAIL stuck_low_recover: driven_slots=%0d state=%0d expected 0 and 0", bad, dut.state_r);
        end
        slot(1'b0);
        send_byte(8'h55);
        slot(1'b1);
        recv_byte(d, all_oe);
        checks++;
        if (d !== 8'h5A || all_oe !== 1'b1) begin
            failures++;
            $display("FAIL stuck_low_read: data=%h drive=%0b expected data=5a drive=1", d, all_oe);
        end
        slot(1'b1);
        slot(1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        m_low    = 1'b0;
        test_reset();
        test_pointer_write();
        test_read();
        test_back_to_back();
        test_addr_mismatch();
        test_reset_mid_read();
        test_stuck_low();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
